// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: captures an operand on start, shifts it one bit
// per cycle for shamt cycles, then pulses done and holds the result.
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   Data,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   w_nextWork;
  logic [WIDTH-1:0]   w_stepWork;
  logic [SHAMT_W-1:0] r_count;
  logic [SHAMT_W-1:0] w_nextCount;
  logic [1:0]         r_op;
  logic [1:0]         w_nextOp;
  logic               w_loadResult;
  logic [WIDTH-1:0]   r_result;

  // One-bit step of the captured operation
  always_comb begin
    w_stepWork = r_work;
    case (r_op)
      2'b00:   w_stepWork = {r_work[WIDTH-2:0], 1'b0};
      2'b01:   w_stepWork = {1'b0, r_work[WIDTH-1:1]};
      2'b10:   w_stepWork = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_stepWork = {r_work[0], r_work[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextWork   = r_work;
    w_nextCount  = r_count;
    w_nextOp     = r_op;
    w_loadResult = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextWork  = Data;
          w_nextOp    = op;
          w_nextCount = shamt;
          if (shamt == '0) begin
            w_nextState  = DONE;
            w_loadResult = 1'b1;
          end else begin
            w_nextState = SHIFT;
          end
        end
      end
      SHIFT: begin
        busy        = 1'b1;
        w_nextWork  = w_stepWork;
        w_nextCount = r_count - 1'b1;
        if (r_count == SHAMT_W'(1)) begin
          w_nextState  = DONE;
          w_loadResult = 1'b1;
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Result is written only on the edge that enters DONE, so it holds across SHIFT
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_work   <= '0;
      r_count  <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_nextState;
      r_work  <= w_nextWork;
      r_count <= w_nextCount;
      r_op    <= w_nextOp;
      if (w_loadResult) begin
        r_result <= w_nextWork;
      end
    end
  end

  assign result = r_result;

endmodule
